// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared fn codes and stage-1 payload type for the execute stage
//   No ports. Exports the FN_* codes, the payload widths and s1_payload_t.
package alu_pkg;

  // Payload field widths. These match the default WIDTH/TAG_W of alu_exec_stage.
  localparam int PKG_WIDTH = 32;
  localparam int PKG_TAG_W = 5;

  localparam logic [5:0] FN_CMPEQ = 6'b000010;
  localparam logic [5:0] FN_CMPLT = 6'b000100;
  localparam logic [5:0] FN_CMPLE = 6'b000110;
  localparam logic [5:0] FN_ADD   = 6'b010000;
  localparam logic [5:0] FN_SUB   = 6'b010001;
  localparam logic [5:0] FN_AND   = 6'b101000;
  localparam logic [5:0] FN_OR    = 6'b101110;
  localparam logic [5:0] FN_XOR   = 6'b100110;
  localparam logic [5:0] FN_SHL   = 6'b110000;
  localparam logic [5:0] FN_SHR   = 6'b110001;
  localparam logic [5:0] FN_SRA   = 6'b110011;

  typedef struct packed {
    logic [PKG_WIDTH-1:0] a;
    logic [PKG_WIDTH-1:0] b;
    logic [5:0]           fn;
    logic [PKG_TAG_W-1:0] tag;
    logic                 illegal;
  } s1_payload_t;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational ALU: compare, add/sub, boolean truth table, shifts
//   i: a, b [WIDTH-1:0], fn[5:0]   o: result[WIDTH-1:0] (0 for unsupported fn)
module alu #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [5:0]       fn,
  output logic [WIDTH-1:0] result
);
  always_comb begin
    result = '0;
    case (fn[5:4])
      2'b00: begin
        case (fn[2:1])
          2'b01:   result = {{(WIDTH-1){1'b0}}, (a == b)};
          2'b10:   result = {{(WIDTH-1){1'b0}}, ($signed(a) <  $signed(b))};
          2'b11:   result = {{(WIDTH-1){1'b0}}, ($signed(a) <= $signed(b))};
          default: result = '0;
        endcase
      end
      2'b01:   result = fn[0] ? (a - b) : (a + b);
      2'b10: begin
        // fn[3:0] is a 2-input truth table indexed per bit by {b,a}.
        for (int i = 0; i < WIDTH; i++) result[i] = fn[{b[i], a[i]}];
      end
      default: begin
        case (fn[1:0])
          2'b00:   result = a << b;
          2'b01:   result = a >> b;
          2'b11:   result = $signed(a) >>> b;
          default: result = '0;
        endcase
      end
    endcase
  end
endmodule

// File: rtl/alu_fn_decode.sv
// rtl/alu_fn_decode.sv - illegal fn detection and shift-amount masking ahead of stage 1
//   i: fn[5:0], b[WIDTH-1:0]   o: illegal, b_eff[WIDTH-1:0]
module alu_fn_decode #(
  parameter int WIDTH = 32
) (
  input  logic [5:0]       fn,
  input  logic [WIDTH-1:0] b,
  output logic             illegal,
  output logic [WIDTH-1:0] b_eff
);
  localparam int SHW = $clog2(WIDTH);

  always_comb begin
    illegal = 1'b0;
    b_eff   = b;
    case (fn[5:4])
      2'b00:   illegal = (fn[2:1] == 2'b00);
      2'b11: begin
        illegal = (fn[1:0] == 2'b10);
        // Shift amount keeps only the low log2(WIDTH) bits, so b=WIDTH shifts by 0.
        b_eff   = {{(WIDTH-SHW){1'b0}}, b[SHW-1:0]};
      end
      default: illegal = 1'b0;
    endcase
  end
endmodule

// File: rtl/alu_exec_stage.sv
// rtl/alu_exec_stage.sv - two-stage valid/ready execute wrapper around alu
//   Optional macro ALU_EXEC_PERF_EN adds perf_ops, perf_stall, perf_illegal counters.
//   i: clk, rst, in_valid, in_a, in_b, in_fn, in_tag, out_ready
//   o: in_ready, out_valid, out_result, out_tag, out_zero, out_illegal
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = PKG_WIDTH,
  parameter int TAG_W = PKG_TAG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [5:0]       in_fn,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_zero,
  output logic             out_illegal
`ifdef ALU_EXEC_PERF_EN
  ,
  output logic [31:0]      perf_ops,
  output logic [31:0]      perf_stall,
  output logic [15:0]      perf_illegal
`endif
);
  s1_payload_t      r_s1;
  logic             r_s1_valid;
  logic             r_s2_valid;
  logic [WIDTH-1:0] r_result;
  logic [TAG_W-1:0] r_tag;
  logic             r_zero;
  logic             r_illegal;

  logic             w_dec_illegal;
  logic [WIDTH-1:0] w_b_eff;
  logic [WIDTH-1:0] w_alu_result;
  logic [WIDTH-1:0] w_s2_result;
  logic             w_s1_advance;

  alu_fn_decode #(.WIDTH(WIDTH)) u_dec (
    .fn      (in_fn),
    .b       (in_b),
    .illegal (w_dec_illegal),
    .b_eff   (w_b_eff)
  );

  alu #(.WIDTH(WIDTH)) u_alu (
    .a      (r_s1.a),
    .b      (r_s1.b),
    .fn     (r_s1.fn),
    .result (w_alu_result)
  );

  // out_ready reaches in_ready only through this term; outputs are all registered.
  assign w_s1_advance = r_s1_valid && (!r_s2_valid || out_ready);
  assign in_ready     = !r_s1_valid || w_s1_advance;
  assign w_s2_result  = r_s1.illegal ? '0 : w_alu_result;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1       <= '0;
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_result   <= '0;
      r_tag      <= '0;
      r_zero     <= 1'b0;
      r_illegal  <= 1'b0;
    end else begin
      if (in_ready) begin
        r_s1_valid <= in_valid;
        if (in_valid) begin
          r_s1 <= '{a: in_a, b: w_b_eff, fn: in_fn, tag: in_tag, illegal: w_dec_illegal};
        end
      end
      if (w_s1_advance) begin
        r_s2_valid <= 1'b1;
        r_result   <= w_s2_result;
        r_tag      <= r_s1.tag;
        r_zero     <= (w_s2_result == '0);
        r_illegal  <= r_s1.illegal;
      end else if (out_ready) begin
        r_s2_valid <= 1'b0;
      end
    end
  end

  assign out_valid   = r_s2_valid;
  assign out_result  = r_result;
  assign out_tag     = r_tag;
  assign out_zero    = r_zero;
  assign out_illegal = r_illegal;

`ifdef ALU_EXEC_PERF_EN
  logic [31:0] r_perf_ops;
  logic [31:0] r_perf_stall;
  logic [15:0] r_perf_illegal;

  // All counters saturate rather than wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_ops     <= '0;
      r_perf_stall   <= '0;
      r_perf_illegal <= '0;
    end else begin
      if (r_s2_valid && out_ready && (r_perf_ops != '1))
        r_perf_ops <= r_perf_ops + 32'd1;
      if (r_s2_valid && !out_ready && (r_perf_stall != '1))
        r_perf_stall <= r_perf_stall + 32'd1;
      if (r_s2_valid && out_ready && r_illegal && (r_perf_illegal != '1))
        r_perf_illegal <= r_perf_illegal + 16'd1;
    end
  end

  assign perf_ops     = r_perf_ops;
  assign perf_stall   = r_perf_stall;
  assign perf_illegal = r_perf_illegal;
`endif
endmodule

// File: tb/tb_alu_exec_stage.sv
// tb/tb_alu_exec_stage.sv - directed self-checking bench for alu_exec_stage
module tb_alu_exec_stage;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [5:0]  in_fn;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_tag;
  logic        out_zero;
  logic        out_illegal;
`ifdef ALU_EXEC_PERF_EN
  logic [31:0] perf_ops;
  logic [31:0] perf_stall;
  logic [15:0] perf_illegal;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] v_a   [20];
  logic [31:0] v_b   [20];
  logic [5:0]  v_fn  [20];
  logic [4:0]  v_tag [20];
  logic [31:0] v_res [20];
  logic        v_ill [20];

  alu_exec_stage dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_fn       (in_fn),
    .in_tag      (in_tag),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_tag     (out_tag),
    .out_zero    (out_zero),
    .out_illegal (out_illegal)
`ifdef ALU_EXEC_PERF_EN
    ,
    .perf_ops    (perf_ops),
    .perf_stall  (perf_stall),
    .perf_illegal(perf_illegal)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b,
                        input logic [5:0] fn, input logic [4:0] tag,
                        input logic [31:0] res, input logic ill);
    v_a[i] = a; v_b[i] = b; v_fn[i] = fn; v_tag[i] = tag; v_res[i] = res; v_ill[i] = ill;
  endtask

  task automatic drive(input int i);
    in_a = v_a[i]; in_b = v_b[i]; in_fn = v_fn[i]; in_tag = v_tag[i];
  endtask

  task automatic chk_out(input int i);
    chk("result", out_result, v_res[i]);
    chk("tag", out_tag, v_tag[i]);
    chk("zero", out_zero, (v_res[i] == 32'd0));
    chk("illegal", out_illegal, v_ill[i]);
  endtask

  // Streams ops s..s+ns-1 with out_ready=1 and expects ops e..e+ne-1 in order.
  task automatic stream(input int s, input int ns, input int e, input int ne, output int cyc);
    int sent = 0;
    int got = 0;
    logic acc;
    cyc = 0;
    out_ready = 1'b1;
    while (got < ne && cyc < 40) begin
      if (sent < ns) begin drive(s + sent); in_valid = 1'b1; end
      else in_valid = 1'b0;
      #1;
      if (in_valid) chk("stream_in_ready", in_ready, 1);
      if (out_valid) begin chk_out(e + got); got++; end
      acc = in_valid && in_ready;
      step();
      if (acc) sent++;
      cyc++;
    end
    in_valid = 1'b0;
    chk("stream_count", got, ne);
  endtask

  initial begin
    int cyc;
    int idx;
    logic acc;

    set_op(0,  32'h7FFF_FFFF, 32'd1,         FN_ADD,   5'd3,  32'h8000_0000, 1'b0);
    set_op(1,  32'd5,         32'd5,         FN_SUB,   5'd4,  32'd0,         1'b0);
    set_op(2,  32'hFFFF_FFFF, 32'd1,         FN_CMPLT, 5'd5,  32'd1,         1'b0);
    set_op(3,  32'hF0F0_F0F0, 32'hFFFF_FFFF, FN_XOR,   5'd6,  32'h0F0F_0F0F, 1'b0);
    for (int i = 0; i < 4; i++)
      set_op(4 + i, i, 32'd100, FN_ADD, 5'(10 + i), 32'(100 + i), 1'b0);
    set_op(8,  32'd9,         32'd9,         6'b110010, 5'd20, 32'd0,        1'b1);
    set_op(9,  32'd1,         32'd2,         6'b000000, 5'd21, 32'd0,        1'b1);
    set_op(10, 32'd2,         32'd3,         FN_ADD,   5'd22, 32'd5,         1'b0);
    set_op(11, 32'd1,         32'd33,        FN_SHL,   5'd23, 32'd2,         1'b0);
    set_op(12, 32'h8000_0000, 32'd31,        FN_SHR,   5'd24, 32'd1,         1'b0);
    set_op(13, 32'h8000_0000, 32'd4,         FN_SRA,   5'd25, 32'hF800_0000, 1'b0);
    set_op(14, 32'd7,         32'd7,         FN_CMPEQ, 5'd26, 32'd1,         1'b0);
    set_op(15, 32'd3,         32'd2,         FN_CMPLE, 5'd27, 32'd0,         1'b0);
    set_op(16, 32'h0000_00F0, 32'h0000_000F, FN_OR,    5'd28, 32'h0000_00FF, 1'b0);
    set_op(17, 32'h0000_FF00, 32'h0000_0FF0, FN_AND,   5'd29, 32'h0000_0F00, 1'b0);

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; drive(0);
    step(); step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", out_result, 0);
    chk("rst_tag", out_tag, 0);
    chk("rst_zero", out_zero, 0);
    chk("rst_illegal", out_illegal, 0);
    chk("rst_in_ready", in_ready, 1);
    rst = 1'b0;

    // Scenario 1: latency of two cycles
    out_ready = 1'b1; drive(0); in_valid = 1'b1; #1;
    chk("t1_in_ready", in_ready, 1);
    step(); in_valid = 1'b0;
    chk("t1_not_yet", out_valid, 0);
    step();
    chk("t1_out_valid", out_valid, 1);
    chk_out(0);
    step();
    chk("t1_drained", out_valid, 0);

    // Scenario 2: back-to-back throughput
    stream(1, 3, 1, 3, cyc);
    chk("t2_cycles", cyc, 5);

    // Scenario 3: backpressure with four ops offered
    out_ready = 1'b0; idx = 0;
    for (int c = 0; c < 5; c++) begin
      if (idx < 4) begin drive(4 + idx); in_valid = 1'b1; end
      else in_valid = 1'b0;
      #1;
      acc = in_valid && in_ready;
      if (c >= 2) begin
        chk("t3_hold_valid", out_valid, 1);
        chk("t3_hold_result", out_result, v_res[4]);
        chk("t3_hold_tag", out_tag, v_tag[4]);
      end
      step();
      if (acc) idx++;
    end
    chk("t3_accepted", idx, 2);
    chk("t3_in_ready_low", in_ready, 0);
    stream(6, 2, 4, 4, cyc);
    chk("t3_drain_cycles", cyc, 4);

    // Scenario 4: illegal fn codes, then a legal op
    stream(8, 3, 8, 3, cyc);
    chk("t4_cycles", cyc, 5);

`ifdef ALU_EXEC_PERF_EN
    chk("perf_ops", perf_ops, 11);
    chk("perf_stall", perf_stall, 3);
    chk("perf_illegal", perf_illegal, 2);
`endif

    // Scenario 5: shifts, compares, booleans
    stream(11, 7, 11, 7, cyc);

    // Scenario 6: reset with both stages full
    out_ready = 1'b0;
    drive(11); in_valid = 1'b1; step();
    drive(12); #1;
    chk("t6_in_ready_fill", in_ready, 1);
    step();
    chk("t6_full_valid", out_valid, 1);
    chk("t6_full_in_ready", in_ready, 0);
    rst = 1'b1; out_ready = 1'b1;
    step();
    rst = 1'b0; in_valid = 1'b0;
    chk("t6_out_valid", out_valid, 0);
    chk("t6_in_ready", in_ready, 1);
    chk("t6_result", out_result, 0);
    chk("t6_tag", out_tag, 0);
`ifdef ALU_EXEC_PERF_EN
    chk("t6_perf_ops", perf_ops, 0);
    chk("t6_perf_stall", perf_stall, 0);
    chk("t6_perf_illegal", perf_illegal, 0);
`endif
    step();
    chk("t6_dropped", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
Two-stage pipelined execute wrapper that feeds operands into the combinational ALU and registers its result for the writeback stage. Upstream (decode/operand fetch) and downstream (writeback) connect through valid/ready handshakes, and the block carries a destination tag alongside each op. Illegal function codes are caught before the ALU, so no X ever reaches writeback.

Parameters:
WIDTH, 32, datapath width of a, b and result
TAG_W, 5, width of the destination-register tag carried with each op

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  upstream op valid
in_ready  output  1  stage 1 can accept an op
in_a  input  WIDTH  operand a
in_b  input  WIDTH  operand b
in_fn  input  6  ALU function code, ALU encoding
in_tag  input  TAG_W  destination tag
out_valid  output  1  result valid
out_ready  input  1  writeback accepts result
out_result  output  WIDTH  ALU result (0 when illegal)
out_tag  output  TAG_W  tag of the op
out_zero  output  1  out_result == 0
out_illegal  output  1  op had an unsupported fn

Behaviour:
- Reset (sync, rst=1 at posedge): s1_valid=0, s2_valid=0; out_valid=0, out_result=0, out_tag=0, out_zero=0, out_illegal=0. Reset overrides any handshake in that cycle. An in-flight op is dropped.
- Transfer rules: an input transfer occurs when in_valid && in_ready. An output transfer occurs when out_valid && out_ready.
- Stage 1 (operand register): loads when in_ready. in_ready = !s1_valid || s1_advance. s1_advance = s1_valid && (!s2_valid || out_ready).
- Stage 2 (result register): loads the ALU output when s1_advance. When s1_advance=0 and out_ready=1, s2_valid clears.
- Timing and throughput: latency is 2 cycles from the input transfer to out_valid. Full throughput is 1 op/cycle. out_* hold stable while out_valid && !out_ready. No combinational path from in_* to out_*. The only combinational path from out_ready is to in_ready.
- fn decode in stage 1, with k = fn[5:4]:
  k=00 compare: fn[2:1] 01=EQ, 10=LT, 11=LE, 00 is illegal. The result is 0 or 1, zero-extended.
  k=01 add/sub: fn[0]=1 selects subtract. Wraps modulo 2^WIDTH.
  k=10 boolean: fn[3:0] is the truth table indexed by {b,a}.
  k=11 shift: fn[1:0] 00=SHL, 01=SHR, 11=SRA, 10 is illegal.
- Shift amount: for k=11, stage 1 captures b masked to its low $clog2(WIDTH) bits. Shift by 32 at WIDTH=32 therefore acts as shift by 0.
- Illegal op: out_illegal=1, out_result=0, out_zero=1. The tag still propagates and the handshake proceeds normally.
- Simultaneous in-transfer and out-transfer with both stages full: stage 2 takes stage 1's op, and stage 1 takes the new op in the same cycle. No bubble.
- out_ready low for N cycles with both stages full: in_ready=0. No op is lost or duplicated.

Optional Feature:
Macro ALU_EXEC_PERF_EN.
- Defined: adds outputs perf_ops [31:0], perf_stall [31:0] and perf_illegal [15:0].
  - perf_ops counts output transfers.
  - perf_stall counts cycles with out_valid && !out_ready.
  - perf_illegal counts output transfers with out_illegal=1.
  - All three reset to 0 and saturate at their maximum value (no wrap).
- Undefined: the ports and counters are absent, and the remaining behaviour is identical.

Decomposition:
- Shared package alu_pkg holds:
  - fn code constants: FN_CMPEQ=6'b000010, FN_CMPLT=6'b000100, FN_CMPLE=6'b000110, FN_ADD=6'b010000, FN_SUB=6'b010001, FN_AND=6'b101000, FN_OR=6'b101110, FN_XOR=6'b100110, FN_SHL=6'b110000, FN_SHR=6'b110001, FN_SRA=6'b110011;
  - a typedef for the stage-1 payload struct {a, b, fn, tag, illegal}.
- One sub-module, alu_fn_decode: combinational illegal detection and shift-amount masking. The existing ALU is instantiated unchanged between the stages.

Test Plan:
1. Reset, then FN_ADD a=0x7FFFFFFF b=1 tag=3, out_ready=1 -> out_valid 2 cycles after the transfer, result 0x80000000, tag 3, zero=0.
2. Back-to-back FN_SUB 5-5, FN_CMPLT 0xFFFFFFFF vs 1, FN_XOR 0xF0F0F0F0^0xFFFFFFFF on consecutive cycles -> results 0 (zero=1), 1, 0x0F0F0F0F on consecutive cycles, in_ready held at 1.
3. out_ready=0 for 5 cycles while 4 ops are offered -> exactly 2 accepted, in_ready=0 thereafter, out_* stable. Then out_ready=1 -> all 4 ops delivered in order with correct tags.
4. fn=6'b110010 and fn=6'b000000 -> out_illegal=1, result 0, zero=1, tags preserved. The next legal op is unaffected.
5. FN_SHL a=1 b=33 (WIDTH=32) -> result 2. FN_SHR a=0x80000000 b=31 -> result 1.
6. rst asserted with both stages full -> next cycle out_valid=0, in_ready=1. With ALU_EXEC_PERF_EN, all counters read 0 and perf_stall matches the stall cycles from scenario 3.
